// File: rtl/lc3_display_pkg.sv
// Shared definitions for the LC-3 debug display arbiter.
//   state_t        : arbiter FSM encoding (IDLE, SHOW)
//   DISPLAY_W      : width of one hex display value (4 digits)
//   DWELL_DEFAULT  : default hold time, 0.5 s at 100 MHz
package lc3_display_pkg;

    localparam int DISPLAY_W     = 16;
    localparam int DWELL_DEFAULT = 50_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req       in  NUM_REQ  request vector
//   pointer   in  SRC_W    highest-priority index for this pick
//   winner    out NUM_REQ  one-hot first requester at or after pointer (wrapping)
//   index     out SRC_W    binary index of winner
//   any_valid out 1        at least one request is present
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [SRC_W-1:0]   index,
    output logic               any_valid
);

    assign any_valid = |req;

    // Walk the candidates in priority order; the first hit wins. The index is
    // wrapped by subtraction so non power-of-two NUM_REQ works.
    always_comb begin
        int               cand;
        logic [SRC_W-1:0] cand_idx;
        logic             found;
        winner   = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(pointer) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = SRC_W'(cand);
            if (!found && req[cand_idx]) begin
                found            = 1'b1;
                winner[cand_idx] = 1'b1;
                index            = cand_idx;
            end
        end
    end

endmodule

// File: rtl/seven_segment_display_arbiter.sv
// Shares one 4-digit hex display among NUM_REQ debug sources. Round-robin
// grant with a minimum dwell per source so each value stays readable.
//   clock         in  1            system clock
//   reset_n       in  1            async active-low reset
//   req           in  NUM_REQ      per-source request, level sensitive
//   req_data      in  16*NUM_REQ   source i value at [16*i+15:16*i]
//   freeze        in  1            hold current grant past dwell expiry
//   grant         out NUM_REQ      registered one-hot grant, zero when idle
//   source_id     out SRC_W        binary index of granted source
//   display_data  out 16           registered value for the display decoder
//   display_valid out 1            high while a source is granted
module seven_segment_display_arbiter
    import lc3_display_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DWELL   = DWELL_DEFAULT,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [DISPLAY_W*NUM_REQ-1:0]   req_data,
    input  logic                           freeze,
    output logic [NUM_REQ-1:0]             grant,
    output logic [SRC_W-1:0]               source_id,
    output logic [DISPLAY_W-1:0]           display_data,
    output logic                           display_valid
);

    localparam int               CNT_W  = $clog2(DWELL);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t                              state;
    logic [CNT_W-1:0]                    count;
    logic [SRC_W-1:0]                    pointer;
    logic [NUM_REQ-1:0][DISPLAY_W-1:0]   data_arr;

    logic [NUM_REQ-1:0]                  pick_onehot;
    logic [SRC_W-1:0]                    pick_idx;
    logic                                pick_any;
    logic [SRC_W-1:0]                    next_ptr;
    logic                                cur_req;

    assign data_arr = req_data;
    assign cur_req  = req[source_id];
    assign next_ptr = (pick_idx == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx + SRC_W'(1);

    // Pointer always sits one past the last winner, so picking from it both
    // starts IDLE arbitration fairly and yields "next requester after the
    // current one" on expiry/release, wrapping back to the current source
    // when it is the only one left.
    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (req),
        .pointer   (pointer),
        .winner    (pick_onehot),
        .index     (pick_idx),
        .any_valid (pick_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            source_id     <= '0;
            display_data  <= '0;
            display_valid <= 1'b0;
            count         <= '0;
            pointer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant         <= pick_onehot;
                        source_id     <= pick_idx;
                        display_valid <= 1'b1;
                        count         <= RELOAD;
                        pointer       <= next_ptr;
                        state         <= SHOW;
                    end
                end
                SHOW: begin
                    // Tracks the live value of the granted source, one cycle behind.
                    display_data <= data_arr[source_id];
                    if (cur_req && count != '0) begin
                        count <= count - CNT_W'(1);
                    end else if (cur_req && freeze) begin
                        // Expired but frozen; a dropped request is never held.
                        count <= '0;
                    end else if (pick_any) begin
                        grant     <= pick_onehot;
                        source_id <= pick_idx;
                        count     <= RELOAD;
                        pointer   <= next_ptr;
                    end else begin
                        // display_data keeps the last shown value while idle.
                        grant         <= '0;
                        display_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
module tb_seven_segment_display_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [16*N-1:0] req_data;
    logic           freeze;
    logic [N-1:0]   grant;
    logic [1:0]     source_id;
    logic [15:0]    display_data;
    logic           display_valid;

    int n_vec = 0;
    int n_err = 0;

    seven_segment_display_arbiter #(.NUM_REQ(N), .DWELL(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .req_data      (req_data),
        .freeze        (freeze),
        .grant         (grant),
        .source_id     (source_id),
        .display_data  (display_data),
        .display_valid (display_valid)
    );

    always #5 clock = ~clock;

    // Reference model: tracks cycles shown so far (counting up) rather than
    // a remaining count, and picks "after current" on rotation.
    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   src;
        logic         valid;
        logic [15:0]  data;
    } exp_t;

    exp_t        sb[$];
    int          m_src, m_el, m_ptr;
    bit          m_valid;
    logic [15:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_src = 0; m_el = 0; m_ptr = 0; m_valid = 0; m_data = 16'h0000;
        sb.delete();
    endtask

    task automatic grant_to(input int w);
        m_src = w; m_valid = 1; m_el = 0; m_ptr = (w + 1) % N;
    endtask

    // Advance the model by the edge the DUT is about to see; push its outputs.
    task automatic model_step();
        exp_t        e;
        logic [15:0] nd;
        int          w;
        if (!m_valid) begin
            if (req != '0) begin
                w = pick(req, m_ptr);
                grant_to(w);
            end
        end else begin
            nd = req_data[m_src*16 +: 16];
            if (req[m_src] && m_el < DW - 1) m_el++;
            else if (req[m_src] && freeze) ;
            else if (req != '0) begin
                w = pick(req, (m_src + 1) % N);
                grant_to(w);
            end else m_valid = 0;
            m_data = nd;
        end
        e.grant = m_valid ? N'(1 << m_src) : '0;
        e.src   = 2'(m_src);
        e.valid = m_valid;
        e.data  = m_data;
        sb.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input logic f);
        exp_t e;
        req = r; freeze = f;
        model_step();
        @(posedge clock); #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.grant));
            chk("valid", 32'(display_valid), 32'(e.valid));
            chk("data",  32'(display_data), 32'(e.data));
            if (e.valid) chk("src", 32'(source_id), 32'(e.src));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; freeze = 1'b0;
        #1;
        model_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(display_valid), 0);
        chk("rst_data",  32'(display_data), 0);
        chk("rst_src",   32'(source_id), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        freeze   = 1'b0;
        req_data = '0;

        // 1: idle after reset
        do_reset();
        for (int i = 0; i < 10; i++) step('0, 1'b0);

        // 2: single source held indefinitely
        do_reset();
        req_data[15:0] = 16'h3000;
        step(4'b0001, 1'b0);
        chk("t2_grant", 32'(grant), 32'h1);
        step(4'b0001, 1'b0);
        chk("t2_data", 32'(display_data), 32'h3000);
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0);
        chk("t2_held", 32'(grant), 32'h1);

        // 3: full rotation, 4 cycles each
        do_reset();
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int k = 1; k <= 20; k++) begin
            step(4'b1111, 1'b0);
            chk("t3_rot", 32'(source_id), 32'(((k - 1) / 4) % 4));
        end

        // 4: freeze holds source 1 past expiry
        do_reset();
        step(4'b0010, 1'b1);
        for (int i = 0; i < 14; i++) begin
            step(4'b0110, 1'b1);
            chk("t4_frz", 32'(grant), 32'h2);
        end
        step(4'b0110, 1'b0);
        chk("t4_rel", 32'(grant), 32'h4);

        // 5: early release, then all drop
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b1011, 1'b0);
        chk("t5_move", 32'(grant), 32'h8);
        step(4'b0000, 1'b0);
        chk("t5_idle", 32'(display_valid), 0);

        // 6: async reset mid-SHOW
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_grant", 32'(grant), 0);
        chk("t6_valid", 32'(display_valid), 0);
        chk("t6_data",  32'(display_data), 0);
        model_reset();
        @(posedge clock); #1 reset_n = 1'b1;
        step(4'b1000, 1'b0);
        chk("t6_src", 32'(source_id), 3);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_data = {$urandom, $urandom};
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
